// File: rtl/loop_unwind_19.sv
// Purpose : replays a forward x/y loop backwards from a loaded terminal pair down to x = 0,
//           rejecting loads that break the invariant y == exp(x) or exceed X_MAX.
// Latency : load accepted at edge N -> first pair valid in cycle N+1; one pair per cycle after that.
// Backpressure: out_ready_i low holds x_o/y_o stable with no step; load_ready_o is high only in IDLE/ERR.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   load_valid_i / load_ready_o  load handshake; load_x_i / load_y_i carry the terminal pair
//   out_valid_o / out_ready_i    replay handshake; x_o / y_o carry the current pair
//   done_o                       one-cycle pulse after the final (x = 0) pair is accepted
//   err_o                        loaded pair was illegal; block waits in ERR for a new load
module loop_unwind_19 #(
    parameter int W      = 11,
    parameter int X_MAX  = 200,
    parameter int THRESH = 100,
    parameter int Y_INIT = 100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid_i,
    output logic         load_ready_o,
    input  logic [W-1:0] load_x_i,
    input  logic [W-1:0] load_y_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic         done_o,
    output logic         err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Constants widened to W+1 bits so the invariant check never truncates.
    localparam logic [W:0]   X_MAX_E  = X_MAX[W:0];
    localparam logic [W:0]   THRESH_E = THRESH[W:0];
    localparam logic [W:0]   Y_INIT_E = Y_INIT[W:0];
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic         out_valid_q, out_valid_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         load_ready_q, load_ready_d;

    // ------------------------------------------------------------------
    // Load-side invariant check: exp(x) = Y_INIT + (x - THRESH) above THRESH.
    // ------------------------------------------------------------------
    logic [W:0] load_x_e;
    logic [W:0] load_y_e;
    logic [W:0] load_exp_y;
    logic       load_bad;

    assign load_x_e = {1'b0, load_x_i};
    assign load_y_e = {1'b0, load_y_i};

    always_comb begin
        load_exp_y = Y_INIT_E;
        if (load_x_e > THRESH_E) begin
            load_exp_y = Y_INIT_E + (load_x_e - THRESH_E);
        end
    end

    assign load_bad = (load_x_e > X_MAX_E) || (load_y_e != load_exp_y);

    // ------------------------------------------------------------------
    // Replay-side step conditions, evaluated on the pre-step x.
    // ------------------------------------------------------------------
    logic x_is_zero;
    logic x_above_thresh;
    logic out_hs;
    logic load_hs;

    assign x_is_zero      = (x_q == '0);
    assign x_above_thresh = ({1'b0, x_q} > THRESH_E);
    assign out_hs         = (state_q == S_RUN) && out_ready_i;
    assign load_hs        = ((state_q == S_IDLE) || (state_q == S_ERR)) && load_valid_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;

        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (load_hs) begin
                    // Offending values are captured too, so ERR can show them.
                    x_d     = load_x_i;
                    y_d     = load_y_i;
                    state_d = load_bad ? S_ERR : S_RUN;
                end
            end
            S_RUN: begin
                if (out_hs) begin
                    if (x_is_zero) begin
                        state_d = S_DONE;
                    end else begin
                        x_d = x_q - ONE;
                        // y only tracks x above the threshold; below it y is flat.
                        if (x_above_thresh) begin
                            y_d = y_q - ONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Flags are decoded from the next state and registered, so every
    // output comes straight from a flop.
    always_comb begin
        out_valid_d  = (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
        load_ready_d = (state_d == S_IDLE) || (state_d == S_ERR);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign out_valid_o  = out_valid_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign load_ready_o = load_ready_q;

endmodule

// File: tb/tb_loop_unwind_19.sv
// Purpose : scoreboard bench for loop_unwind_19; stimulus pushes expected replay pairs,
//           a negedge monitor pops and compares on every accepted beat.
// Latency : checks first-beat latency, done timing and error visibility cycle by cycle.
module tb_loop_unwind_19;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_x;
    logic [W-1:0] load_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    loop_unwind_19 #(.W(W), .X_MAX(200), .THRESH(100), .Y_INIT(100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .load_x_i     (load_x),
        .load_y_i     (load_y),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .x_o          (x),
        .y_o          (y),
        .done_o       (done),
        .err_o        (err)
    );

    typedef struct packed {
        logic [W-1:0] px;
        logic [W-1:0] py;
    } pair_t;

    pair_t        exp_q[$];
    pair_t        mon_e;
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    logic         last_pend = 1'b0;
    logic         after_done = 1'b0;
    logic         hold_vld = 1'b0;
    logic [W-1:0] hold_x;
    logic [W-1:0] hold_y;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Reference y for a given x, straight from the loop invariant.
    function automatic int expy(input int xv);
        return (xv > 100) ? 100 + (xv - 100) : 100;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: samples at negedge, away from the active edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst_n) begin
            last_pend  = 1'b0;
            after_done = 1'b0;
            hold_vld   = 1'b0;
        end else begin
            if (done) done_cnt++;
            check("done_pulse", int'(done), int'(last_pend));
            if (last_pend) begin
                check("valid_in_done", int'(out_valid), 0);
                check("ready_in_done", int'(load_ready), 0);
            end
            if (after_done) check("ready_after_done", int'(load_ready), 1);
            after_done = last_pend;
            last_pend  = 1'b0;
            if (hold_vld && out_valid) begin
                check("stall_x", int'(x), int'(hold_x));
                check("stall_y", int'(y), int'(hold_y));
            end
            hold_vld = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", int'(x), -1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat_x", int'(x), int'(mon_e.px));
                        check("beat_y", int'(y), int'(mon_e.py));
                        if (mon_e.px == '0) last_pend = 1'b1;
                    end
                end else begin
                    hold_vld = 1'b1;
                    hold_x   = x;
                    hold_y   = y;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic do_load(input int lx, input int ly);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        load_x     = lx[W-1:0];
        load_y     = ly[W-1:0];
        load_valid = 1'b1;
        while (n < 50) begin
            @(negedge clk);
            if (load_ready) break;
            n++;
        end
        if (n >= 50) check("load_timeout", 0, 1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic push_seq(input int n);
        pair_t p;
        for (int i = n; i >= 0; i--) begin
            p.px = i[W-1:0];
            p.py = expy(i) & 32'h7FF;
            exp_q.push_back(p);
        end
    endtask

    task automatic run_seq(input int n, input bit bp);
        int dc;
        int cnt;
        push_seq(n);
        dc = done_cnt;
        do_load(n, expy(n));
        @(negedge clk);
        check("first_valid", int'(out_valid), 1);
        check("err_clear", int'(err), 0);
        check("load_ready_run", int'(load_ready), 0);
        cnt = 0;
        while (done_cnt == dc && cnt < 5000) begin
            @(posedge clk);
            #1;
            if (bp) out_ready = 1'($urandom_range(0, 1));
            cnt++;
        end
        out_ready = 1'b1;
        check("done_count", done_cnt - dc, 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic bad_load(input int lx, input int ly);
        do_load(lx, ly);
        repeat (3) begin
            @(negedge clk);
            check("err_set", int'(err), 1);
            check("err_no_valid", int'(out_valid), 0);
            check("err_hold_x", int'(x), lx);
            check("err_hold_y", int'(y), ly);
            check("err_load_ready", int'(load_ready), 1);
        end
    endtask

    initial begin
        int dc;
        int n;
        load_valid = 1'b0;
        load_x     = '0;
        load_y     = '0;
        out_ready  = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_load_ready", int'(load_ready), 1);
        rst_n = 1'b1;

        // Full-range replay, then mid, then minimal
        run_seq(200, 1'b0);
        run_seq(100, 1'b0);
        run_seq(0, 1'b0);

        // Invariant violation and recovery
        bad_load(150, 140);
        run_seq(101, 1'b0);

        // Out-of-range x, then bad y below threshold (loaded from ERR)
        bad_load(201, 201);
        bad_load(50, 99);

        // Backpressure with a load from ERR
        run_seq(105, 1'b1);

        // Asynchronous reset mid-replay
        push_seq(200);
        do_load(200, 200);
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (x == 11'd120) break;
            n++;
        end
        check("reach_120", int'(x), 120);
        dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_x", int'(x), 0);
        check("arst_y", int'(y), 0);
        check("arst_done", int'(done), 0);
        check("arst_load_ready", int'(load_ready), 1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_done", done_cnt - dc, 0);
        check("arst_ready_after", int'(load_ready), 1);
        run_seq(3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loop_unwind_19.md
# loop_unwind_19

Reverse-direction companion to the bounded x/y loop counter. Accepts a terminal (x, y) pair from the forward loop through a valid/ready load port and validates it against the loop invariant. It then replays the loop backwards, streaming every (x, y) pair from the loaded value down to x = 0 on a valid/ready output port. It sits downstream of the forward counter as the consumer/checker of its final state.

## Interface
- W, 11, width of x and y
- X_MAX, 200, largest legal x (forward loop bound)
- THRESH, 100, x threshold above which y tracks x
- Y_INIT, 100, y value for all x <= THRESH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- load_valid  in  1  load pair offered
- load_ready  out  1  block can accept a load (IDLE or ERR)
- load_x  in  W  terminal x
- load_y  in  W  terminal y
- out_valid  out  1  x/y hold a valid replay pair
- out_ready  in  1  consumer accepts pair
- x  out  W  current replay x
- y  out  W  current replay y
- done  out  1  one-cycle pulse after last pair accepted
- err  out  1  loaded pair violated invariant; held in ERR

## Operation
- States: IDLE, RUN, DONE, ERR.
- Expected y for a given x: exp(x) = Y_INIT + (x - THRESH) if x > THRESH, else Y_INIT; computed in W+1 bits, no truncation.
- IDLE:
  - load_ready=1.
  - On load_valid: capture load_x/load_y into x/y.
  - If load_x > X_MAX or load_y != exp(load_x): go to ERR.
  - Else: go to RUN.
- RUN:
  - out_valid=1, load_ready=0.
  - On out_valid && out_ready with x == 0: go to DONE.
  - Otherwise, on that handshake, step backwards: x <= x-1; y <= y-1 if x > THRESH (pre-step x), else y unchanged.
  - Steps are the exact inverse of the forward step; every emitted pair satisfies y == exp(x).
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE.
- ERR:
  - err=1, out_valid=0, load_ready=1; x/y hold the offending captured values.
  - A new load is handled exactly as in IDLE, and err drops in the cycle after that load is accepted.
- Loading x=n yields exactly n+1 output beats, last beat (0, Y_INIT).
- load_valid is ignored outside IDLE/ERR.
- Arithmetic never wraps: x=0 never decrements; y decrements only while x > THRESH >= 0.

## Timing
- Reset (rst_n low, async) forces: state IDLE, x=0, y=0, out_valid=0, done=0, err=0, load_ready=1 after reset.
- Reset asserted mid-RUN aborts the replay immediately. No done pulse is produced.
- Load accepted at edge N: out_valid=1 with the loaded pair from cycle N+1 (one-cycle latency). Errors are likewise visible (err=1) from N+1.
- Back-to-back throughput: one pair per cycle while out_ready=1.
- While out_valid=1 and out_ready=0: x and y are held stable, no step.
- Last handshake at edge M: done=1 and out_valid=0 during cycle M+1; IDLE and load_ready=1 at M+2.
- All outputs are registered. No combinational path from out_ready or load_valid to x/y.

## Test plan
- Load (200, 200), out_ready=1 constantly:
  - Exactly 201 beats: (200,200), (199,199) … (101,101), (100,100), (99,100) … (0,100).
  - done pulses once, one cycle after beat (0,100).
- Load (100, 100):
  - 101 beats, y constant 100 throughout.
  - Then load (0, 100): single beat (0,100), done pulse.
- Invariant violations:
  - Load (150, 140): err=1 from next cycle, out_valid never asserts, x/y hold (150,140).
  - Then load (101, 101): err clears, replay (101,101), (100,100), … (0,100).
- Load (201, 201) (> X_MAX): ERR. Load (50, 99): ERR.
- Backpressure: load (105, 105), toggle out_ready pseudo-randomly. Accepted sequence is identical to the free-running case; x/y never change while out_valid && !out_ready.
- Drop rst_n asynchronously mid-RUN at pair (120,120): outputs clear without waiting for clk. No done pulse. After release, load_ready=1 and a fresh load (3,100) replays (3,100)…(0,100).
